// File: rtl/excess_3_deserializer.sv
// excess_3_deserializer: regroups an LSB-first serial Excess-3 stream into N_DIGITS-digit words behind a valid/ready register.
// Define EX3_TO_BCD_EN to store BCD (code-3, or 4'hF for invalid codes) instead of raw Excess-3 codes.
module excess_3_deserializer #(
    parameter int N_DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  B_in,
    input  logic                  en,
    output logic [4*N_DIGITS-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  word_err,
    output logic                  digit_err,
    output logic                  overrun
);
    localparam int W  = 4 * N_DIGITS;
    localparam int DW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    logic [3:0]    nib;
    logic [1:0]    bit_cnt;
    logic [DW-1:0] digit_cnt;
    logic [W-1:0]  asm_word;
    logic [W-1:0]  nxt_word;
    logic          acc_err;
    logic [3:0]    code;
    logic [3:0]    slot;
    logic          bad;
    logic          digit_done;
    logic          last_digit;
    logic          word_done;
    logic          load;
    assign code       = {B_in, nib[3:1]};
    assign bad        = code < 4'd3 || code > 4'd12;
    assign digit_done = en && bit_cnt == 2'd3;
    assign last_digit = digit_cnt == DW'(N_DIGITS - 1);
    assign word_done  = digit_done && last_digit;
    assign load       = word_done && (!word_valid || word_ready);
`ifdef EX3_TO_BCD_EN
    assign slot = bad ? 4'hF : code - 4'd3;
`else
    assign slot = code;
`endif
    always_comb begin
        nxt_word = asm_word;
        nxt_word[4*digit_cnt +: 4] = slot;
    end
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            nib        <= '0;
            bit_cnt    <= '0;
            digit_cnt  <= '0;
            asm_word   <= '0;
            acc_err    <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_err   <= 1'b0;
            digit_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            digit_err <= digit_done && bad;
            overrun   <= word_done && word_valid && !word_ready;
            if (en) begin
                nib     <= code;
                bit_cnt <= bit_cnt + 2'd1;
            end
            if (digit_done) begin
                asm_word  <= nxt_word;
                digit_cnt <= last_digit ? '0 : digit_cnt + DW'(1);
                acc_err   <= last_digit ? 1'b0 : acc_err | bad;
            end
            // a load on the same edge as a take keeps word_valid high (back-to-back)
            if (load) begin
                word_out   <= nxt_word;
                word_err   <= acc_err | bad;
                word_valid <= 1'b1;
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_excess_3_deserializer.sv
// tb_excess_3_deserializer: directed vectors for the N_DIGITS=2 build; expectations follow EX3_TO_BCD_EN.
module tb_excess_3_deserializer;
`ifdef EX3_TO_BCD_EN
    localparam bit BCD = 1'b1;
`else
    localparam bit BCD = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       B_in = 1'b0;
    logic       en = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word_out;
    logic       word_valid, word_err, digit_err, overrun;
    int         checks = 0;
    int         errors = 0;

    excess_3_deserializer #(.N_DIGITS(2)) dut (
        .clk(clk), .reset_b(reset_b), .B_in(B_in), .en(en),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .word_err(word_err), .digit_err(digit_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sends bits v[lo..hi-1] LSB first; gap inserts an en=0 cycle after each bit
    task automatic send(input logic [7:0] v, input int lo, input int hi, input bit gap);
        for (int i = lo; i < hi; i++) begin
            B_in = v[i];
            en   = 1'b1;
            tick();
            en   = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic do_reset();
        #2;
        reset_b = 1'b0;
        #2;
        check("rst_valid", word_valid, 0);
        check("rst_word", word_out, 0);
        check("rst_err", {word_err, digit_err, overrun}, 0);
        tick();
        reset_b = 1'b1;
        tick();
    endtask

    task automatic take();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("take_valid", word_valid, 0);
    endtask

    initial begin
        do_reset();
        send(8'hC3, 0, 7, 0);
        check("s1_valid7", word_valid, 0);
        send(8'hC3, 7, 8, 0);
        check("s1_valid", word_valid, 1);
        check("s1_word", word_out, BCD ? 8'h90 : 8'hC3);
        check("s1_err", word_err, 0);
        check("s1_derr", digit_err, 0);
        tick();
        tick();
        check("s1_hold", word_valid, 1);
        check("s1_hold_word", word_out, BCD ? 8'h90 : 8'hC3);
        take();

        send(8'hC3, 0, 7, 1);
        check("s2_valid7", word_valid, 0);
        send(8'hC3, 7, 8, 0);
        check("s2_valid", word_valid, 1);
        check("s2_word", word_out, BCD ? 8'h90 : 8'hC3);
        check("s2_err", word_err, 0);
        take();

        send(8'hC0, 0, 4, 0);
        check("s3_derr", digit_err, 1);
        send(8'hC0, 4, 5, 0);
        check("s3_derr_end", digit_err, 0);
        send(8'hC0, 5, 8, 0);
        check("s3_valid", word_valid, 1);
        check("s3_word", word_out, BCD ? 8'h9F : 8'hC0);
        check("s3_err", word_err, 1);
        check("s3_derr_last", digit_err, 0);
        take();

        send(8'hC3, 0, 8, 0);
        send(8'h54, 0, 8, 0);
        check("s4_overrun", overrun, 1);
        check("s4_valid", word_valid, 1);
        check("s4_word", word_out, BCD ? 8'h90 : 8'hC3);
        tick();
        check("s4_overrun_end", overrun, 0);
        take();

        send(8'hC3, 0, 8, 0);
        send(8'h54, 0, 7, 0);
        word_ready = 1'b1;
        send(8'h54, 7, 8, 0);
        word_ready = 1'b0;
        check("s5_valid", word_valid, 1);
        check("s5_word", word_out, BCD ? 8'h21 : 8'h54);
        check("s5_overrun", overrun, 0);
        check("s5_err", word_err, 0);

        send(8'hC3, 0, 6, 0);
        do_reset();
        send(8'hA5, 0, 4, 0);
        check("s6_derr", digit_err, 0);
        send(8'hA5, 4, 8, 0);
        check("s6_valid", word_valid, 1);
        check("s6_word", word_out, BCD ? 8'h72 : 8'hA5);
        check("s6_err", word_err, 0);
        check("s6_derr_last", digit_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/excess_3_deserializer.md
Name: excess_3_deserializer

Overview:
- Downstream stage of the serial BCD-to-Excess-3 converter: consumes its LSB-first serial Excess-3 bit stream.
- Regroups every 4 bits into one digit code and assembles N_DIGITS digits into a parallel word.
- Checks each code for Excess-3 validity and presents the word through a valid/ready handshake.
- A one-word output register decouples the consumer from the continuous serial stream.

Parameters:
- N_DIGITS, 2, number of 4-bit digits packed per output word (1..8).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- B_in  input  1  serial Excess-3 bit from the converter, LSB of each digit first.
- en  input  1  bit qualifier; B_in is sampled only on edges where en=1.
- word_out  output  4*N_DIGITS  assembled word; digit 0 (first received) in bits [3:0].
- word_valid  output  1  word_out holds an untaken word.
- word_ready  input  1  consumer accepts the word on an edge where word_valid=1.
- word_err  output  1  qualified by word_valid: at least one digit in word_out was invalid.
- digit_err  output  1  one-cycle pulse: the digit just completed was not in 3..12.
- overrun  output  1  one-cycle pulse: a completed word was dropped because the output register was full.

Behaviour:
- Reset (async, reset_b=0): bit_cnt=0, digit_cnt=0, shift and assembly registers=0, word_out=0, word_valid=0, word_err=0, digit_err=0, overrun=0.
- Framing is implicit:
  - The first en=1 edge after reset release is bit 0 of digit 0.
  - No resynchronisation exists other than reset.
  - Reset mid-digit or mid-word discards all partial data.
- Bit capture, on en=1:
  - nib <= {B_in, nib[3:1]}; bit_cnt increments modulo 4.
  - en=0 edges hold all counters and registers.
- Digit completion (en=1 and bit_cnt=3):
  - code = {B_in, nib[3:1]}.
  - code is written to assembly slot digit_cnt.
  - The digit is invalid if code<3 or code>12. If invalid: digit_err=1 for the next cycle only, and the per-word error flag is set.
  - digit_cnt increments modulo N_DIGITS.
- Word completion (digit completion with digit_cnt=N_DIGITS-1), on the same edge as the final digit:
  - If word_valid=0, or word_valid=1 and word_ready=1: word_out <= completed word, word_err <= accumulated flag, word_valid <= 1.
  - Otherwise the word is dropped, overrun pulses for one cycle, and word_out, word_err and word_valid are unchanged.
  - In both cases the per-word error flag clears for the next word.
- Latency: word_valid rises the cycle after the edge that samples the final bit. Minimum spacing between words is 4*N_DIGITS en cycles.
- Handshake:
  - word_valid stays high, with word_out and word_err stable, until an edge with word_ready=1.
  - On that edge word_valid clears, unless a new word loads on the same edge; then it stays 1 with the new data (back-to-back).
  - word_ready while word_valid=0 has no effect.
- Simultaneous digit_err and overrun on the final digit: both pulse.

Optional Feature:
- Macro: EX3_TO_BCD_EN.
- Defined:
  - Each valid slot in word_out holds BCD (code-3, 0..9).
  - Each invalid slot holds 4'hF.
  - Validity checking, word_err and digit_err are unchanged.
  - No added latency: conversion happens when the digit is written to its slot.
- Undefined: word_out holds the raw Excess-3 codes as received.

Test Plan:
- Reset, then en=1 with B_in = 1,1,0,0 (code 0011, BCD 0) followed by 0,0,1,1 (code 1100, BCD 9), word_ready=0 (N_DIGITS=2):
  - word_valid=1 one cycle after the 8th bit.
  - word_out=8'hC3, or 8'h90 with EX3_TO_BCD_EN.
  - word_err=0.
- Same stream with en toggled 1,0,1,0...: identical result; word_valid rises one cycle after the 8th en=1 edge.
- Digit bits 0,0,0,0 (code 0000), then digit 1100:
  - digit_err pulses once after the 4th bit.
  - word_out=8'hC0, or 8'h9F with the macro.
  - word_err=1.
- Two full words with word_ready held 0:
  - First word remains in word_out.
  - overrun pulses one cycle after the 16th bit.
  - word_valid stays 1.
- word_ready=1 on the edge where the second word completes: word_valid stays 1, word_out updates to the second word, no overrun.
- reset_b pulsed low after 6 bits, then a fresh 8-bit stream: first word output equals only the post-reset digits; no digit_err and no stale data.
